// File: rtl/alu_ctrl.sv
// -----------------------------------------------------------------------------
// alu_ctrl - initiator-side sequencer for the ALU operation interface.
//
// Accepts one operation request from the CPU control path, drives the ALU
// operand/opcode/start lines, waits for the operation to complete and returns
// the low result word, the high word (MUL upper word / DIV remainder) and the
// ALU flags on a valid/ready response channel. All ALU timing knowledge lives
// here: the ALU updates on the falling edge of CLK, fixed-latency operations
// are sampled two rising edges after issue, and DIV uses a start/finished
// handshake guarded by a timeout.
//
// Ports:
//   CLK, RESET_N        clock (rising edge) / asynchronous active-low reset
//   req_valid/ready     request handshake; req_op, req_a, req_b request fields
//   rsp_valid/ready     response handshake; response held until rsp_ready
//   rsp_result/high     low result word / MUL upper word or DIV remainder
//   rsp_flags           ALU flags {POSITIVE, OVERFLOW, CARRY, ZERO}
//   rsp_err             illegal opcode, divide by zero or DIV timeout
//   alu_a/b/opcode      operands and opcode driven to the ALU (opcode 0 = hold)
//   alu_start           one-cycle DIV start pulse
//   alu_finished        DIV completion from the ALU
//   alu_result/high/flags  ALU outputs
// -----------------------------------------------------------------------------
module alu_ctrl #(
  parameter int N            = 16,
  parameter int ALU_OP_COUNT = 4,
  parameter int FLAGS_COUNT  = 4,
  parameter int DIV_TIMEOUT  = 64
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ALU_OP_COUNT-1:0] req_op,
  input  logic [N-1:0]            req_a,
  input  logic [N-1:0]            req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [N-1:0]            rsp_result,
  output logic [N-1:0]            rsp_high,
  output logic [FLAGS_COUNT-1:0]  rsp_flags,
  output logic                    rsp_err,
  output logic [N-1:0]            alu_a,
  output logic [N-1:0]            alu_b,
  output logic [ALU_OP_COUNT-1:0] alu_opcode,
  output logic                    alu_start,
  input  logic                    alu_finished,
  input  logic [N-1:0]            alu_result,
  input  logic [N-1:0]            alu_high,
  input  logic [FLAGS_COUNT-1:0]  alu_flags
);

  localparam logic [ALU_OP_COUNT-1:0] OP_NONE = '0;
  localparam logic [ALU_OP_COUNT-1:0] OP_ADD  = ALU_OP_COUNT'(1);
  localparam logic [ALU_OP_COUNT-1:0] OP_MUL  = ALU_OP_COUNT'(3);
  localparam logic [ALU_OP_COUNT-1:0] OP_DIV  = ALU_OP_COUNT'(4);
  localparam logic [ALU_OP_COUNT-1:0] OP_SHR  = ALU_OP_COUNT'(10);

  // Wide enough to hold DIV_TIMEOUT itself.
  localparam int CW = $clog2(DIV_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    CAPT,
    DIV_START,
    DIV_WAIT,
    RESP
  } state_t;

  state_t        state;
  logic [CW-1:0] div_cnt;

  logic op_legal;
  logic op_reject;

  // Opcodes 1..10 are implemented by the ALU; a DIV by zero is rejected up
  // front so the divider is never started on it.
  assign op_legal  = (req_op >= OP_ADD) && (req_op <= OP_SHR);
  assign op_reject = !op_legal || ((req_op == OP_DIV) && (req_b == '0));

  // NOTE: all state and outputs are updated with non-blocking assignments so
  // every register samples the values from before the edge, independent of
  // statement order inside the block.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      // NOTE: every register here is a control/data flop that must come out
      // of reset in a known state; the async clear also abandons any ALU
      // operation in flight by forcing opcode 0 (ALU holds) and start low.
      state      <= IDLE;
      div_cnt    <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_high   <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= OP_NONE;
      alu_start  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            alu_a     <= req_a;
            alu_b     <= req_b;
            if (op_reject) begin
              // Answer immediately without touching the ALU.
              rsp_valid  <= 1'b1;
              rsp_err    <= 1'b1;
              rsp_result <= '0;
              rsp_high   <= '0;
              rsp_flags  <= '0;
              state      <= RESP;
            end else begin
              alu_opcode <= req_op;
              rsp_err    <= 1'b0;
              if (req_op == OP_DIV) begin
                alu_start <= 1'b1;
                state     <= DIV_START;
              end else begin
                state <= EXEC;
              end
            end
          end
        end

        // ALU picks up the new operands on the falling edge inside EXEC and
        // its outputs are settled by the end of CAPT.
        EXEC: state <= CAPT;

        CAPT: begin
          rsp_result <= alu_result;
          rsp_flags  <= alu_flags;
          rsp_high   <= (alu_opcode == OP_MUL) ? alu_high : '0;
          alu_opcode <= OP_NONE;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end

        DIV_START: begin
          alu_start <= 1'b0;
          div_cnt   <= '0;
          state     <= DIV_WAIT;
        end

        DIV_WAIT: begin
          // A completion on the same edge as the timeout takes priority.
          if (alu_finished) begin
            rsp_result <= alu_result;
            rsp_high   <= alu_high;
            rsp_flags  <= alu_flags;
            rsp_err    <= 1'b0;
            alu_opcode <= OP_NONE;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else if (div_cnt == CNT_LAST) begin
            rsp_result <= '0;
            rsp_high   <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b1;
            alu_opcode <= OP_NONE;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else begin
            div_cnt <= div_cnt + CW'(1);
          end
        end

        RESP: begin
          // Returning to IDLE here means the next request is taken one edge
          // after the response is consumed, never on the same edge.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          rsp_valid  <= 1'b0;
          alu_opcode <= OP_NONE;
          alu_start  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_ctrl - self-checking bench for alu_ctrl.
//
// A small behavioural ALU responds on the falling clock edge. Fixed-latency
// and rejected operations run from a table of hand-computed vectors; DIV
// timeout with response back-pressure and reset during DIV_WAIT are
// hand-written sequences.
// -----------------------------------------------------------------------------
module tb_alu_ctrl;

  localparam int N           = 16;
  localparam int DIV_TIMEOUT = 64;

  logic        CLK;
  logic        RESET_N;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [15:0] rsp_high;
  logic [3:0]  rsp_flags;
  logic        rsp_err;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_opcode;
  logic        alu_start;
  logic        alu_finished = 1'b0;
  logic [15:0] alu_result   = '0;
  logic [15:0] alu_high     = '0;
  logic [3:0]  alu_flags    = '0;

  alu_ctrl #(
    .N(N), .ALU_OP_COUNT(4), .FLAGS_COUNT(4), .DIV_TIMEOUT(DIV_TIMEOUT)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_high(rsp_high), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_start(alu_start), .alu_finished(alu_finished),
    .alu_result(alu_result), .alu_high(alu_high), .alu_flags(alu_flags)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------------------------------------------------------------------
  // Behavioural ALU: updates on the falling edge, opcode 0 holds state.
  // Non-MUL/DIV ops drive a junk high word so the controller's masking shows.
  // ---------------------------------------------------------------------------
  logic [3:0]  div_cnt_m = '0;
  logic        div_hang  = 1'b0;
  logic [16:0] t17;
  logic [31:0] p32;
  logic [15:0] r16;
  int          start_cnt = 0;

  function automatic logic [3:0] mk_flags(logic [15:0] r, logic ov, logic cy);
    return {~r[15] & (r != 16'h0), ov, cy, (r == 16'h0)};
  endfunction

  always @(negedge CLK) begin
    if (alu_start) start_cnt = start_cnt + 1;
    if (alu_opcode == 4'd0) begin
      alu_finished <= 1'b0;
    end else if (alu_opcode == 4'd4) begin
      if (alu_start) begin
        div_cnt_m    <= 4'd3;
        alu_finished <= 1'b0;
      end else if (!div_hang && div_cnt_m != 4'd0) begin
        div_cnt_m <= div_cnt_m - 4'd1;
        if (div_cnt_m == 4'd1) begin
          r16 = alu_a / alu_b;
          alu_result   <= r16;
          alu_high     <= alu_a % alu_b;
          alu_flags    <= mk_flags(r16, 1'b0, 1'b0);
          alu_finished <= 1'b1;
        end
      end
    end else begin
      alu_high <= 16'hDEAD;
      case (alu_opcode)
        4'd1: begin
          t17 = {1'b0, alu_a} + {1'b0, alu_b};
          alu_result <= t17[15:0];
          alu_flags  <= mk_flags(t17[15:0],
                          (alu_a[15] == alu_b[15]) && (t17[15] != alu_a[15]), t17[16]);
        end
        4'd2: begin
          r16 = alu_a - alu_b;
          alu_result <= r16;
          alu_flags  <= mk_flags(r16,
                          (alu_a[15] != alu_b[15]) && (r16[15] != alu_a[15]), alu_a < alu_b);
        end
        4'd3: begin
          p32 = alu_a * alu_b;
          alu_result <= p32[15:0];
          alu_high   <= p32[31:16];
          alu_flags  <= mk_flags(p32[15:0], 1'b0, 1'b0);
        end
        4'd5: begin r16 = alu_a & alu_b; alu_result <= r16; alu_flags <= mk_flags(r16, 1'b0, 1'b0); end
        4'd6: begin r16 = alu_a | alu_b; alu_result <= r16; alu_flags <= mk_flags(r16, 1'b0, 1'b0); end
        4'd7: begin r16 = alu_a ^ alu_b; alu_result <= r16; alu_flags <= mk_flags(r16, 1'b0, 1'b0); end
        4'd8: begin r16 = -alu_a; alu_result <= r16; alu_flags <= mk_flags(r16, 1'b0, 1'b0); end
        4'd9: begin
          r16 = {alu_a[14:0], 1'b0};
          alu_result <= r16; alu_flags <= mk_flags(r16, 1'b0, alu_a[15]);
        end
        4'd10: begin
          r16 = {1'b0, alu_a[15:1]};
          alu_result <= r16; alu_flags <= mk_flags(r16, 1'b0, alu_a[0]);
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one request starting just after a rising edge; returns just after
  // the edge on which it was accepted.
  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    check("req_ready before issue", req_ready, 1'b1);
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    @(posedge CLK); #1;
    req_valid = 1'b0;
  endtask

  // Count edges from the accept edge until rsp_valid is seen; also report
  // whether alu_opcode held the expected drive value while waiting.
  task automatic wait_rsp(input logic [3:0] drv, output int k, output logic held);
    k    = 0;
    held = 1'b1;
    while (!rsp_valid && k < 200) begin
      if (alu_opcode !== drv) held = 1'b0;
      @(posedge CLK); #1;
      k++;
    end
    check("rsp_valid within bound", rsp_valid, 1'b1);
  endtask

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] result;
    logic [15:0] high;
    logic [3:0]  flags;   // {POSITIVE, OVERFLOW, CARRY, ZERO}
    logic        err;
    int          lat;     // edges after accept until rsp_valid; -1 = don't care
    int          starts;  // cycles alu_start is high
    logic [3:0]  drv;     // alu_opcode expected while the op is in flight
  } vec_t;

  vec_t vecs[15];

  task automatic run_vec(input vec_t v);
    int   k;
    int   s0;
    logic held;
    s0 = start_cnt;
    issue(v.op, v.a, v.b);
    wait_rsp(v.drv, k, held);
    if (v.lat >= 0) check({v.name, " latency"}, k, v.lat);
    check({v.name, " result"}, rsp_result, v.result);
    check({v.name, " high"},   rsp_high,   v.high);
    check({v.name, " flags"},  rsp_flags,  v.flags);
    check({v.name, " err"},    rsp_err,    v.err);
    check({v.name, " opcode held"}, held, 1'b1);
    check({v.name, " start cycles"}, start_cnt - s0, v.starts);
    check({v.name, " req_ready in RESP"}, req_ready, 1'b0);
    @(posedge CLK); #1;
    check({v.name, " rsp_valid cleared"}, rsp_valid, 1'b0);
    check({v.name, " back to idle"}, req_ready, 1'b1);
    check({v.name, " opcode idle"}, alu_opcode, 4'd0);
  endtask

  initial begin
    int   k;
    int   s0;
    logic held;

    //           name        op     a        b        result   high     flags    err lat st drv
    vecs[0]  = '{"add_ovf",  4'd1,  16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 4'b0100, 1'b0, 2, 0, 4'd1};
    vecs[1]  = '{"add_cy",   4'd1,  16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 4'b0011, 1'b0, 2, 0, 4'd1};
    vecs[2]  = '{"sub",      4'd2,  16'h0005, 16'h0003, 16'h0002, 16'h0000, 4'b1000, 1'b0, 2, 0, 4'd2};
    vecs[3]  = '{"sub_zero", 4'd2,  16'h0003, 16'h0003, 16'h0000, 16'h0000, 4'b0001, 1'b0, 2, 0, 4'd2};
    vecs[4]  = '{"mul",      4'd3,  16'h1234, 16'h0100, 16'h3400, 16'h0012, 4'b1000, 1'b0, 2, 0, 4'd3};
    vecs[5]  = '{"and",      4'd5,  16'hF0F0, 16'h0FF0, 16'h00F0, 16'h0000, 4'b1000, 1'b0, 2, 0, 4'd5};
    vecs[6]  = '{"or",       4'd6,  16'h1200, 16'h0034, 16'h1234, 16'h0000, 4'b1000, 1'b0, 2, 0, 4'd6};
    vecs[7]  = '{"xor",      4'd7,  16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 4'b0001, 1'b0, 2, 0, 4'd7};
    vecs[8]  = '{"neg",      4'd8,  16'h0001, 16'h0000, 16'hFFFF, 16'h0000, 4'b0000, 1'b0, 2, 0, 4'd8};
    vecs[9]  = '{"shl",      4'd9,  16'h8001, 16'h0000, 16'h0002, 16'h0000, 4'b1010, 1'b0, 2, 0, 4'd9};
    vecs[10] = '{"shr",      4'd10, 16'h0003, 16'h0000, 16'h0001, 16'h0000, 4'b1010, 1'b0, 2, 0, 4'd10};
    vecs[11] = '{"div",      4'd4,  16'd100,  16'd7,    16'd14,   16'd2,    4'b1000, 1'b0, -1, 1, 4'd4};
    vecs[12] = '{"div_big",  4'd4,  16'hFFFF, 16'h0010, 16'h0FFF, 16'h000F, 4'b1000, 1'b0, -1, 1, 4'd4};
    // Rejected requests answer on the accept edge itself, ALU left idle.
    vecs[13] = '{"div_zero", 4'd4,  16'd100,  16'd0,    16'h0000, 16'h0000, 4'b0000, 1'b1, 0, 0, 4'd0};
    vecs[14] = '{"op_0c",    4'hC,  16'h1111, 16'h2222, 16'h0000, 16'h0000, 4'b0000, 1'b1, 0, 0, 4'd0};

    RESET_N   = 1'b0;
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;

    repeat (3) @(posedge CLK);
    #1;
    check("reset rsp_valid",  rsp_valid,  1'b0);
    check("reset rsp_result", rsp_result, 16'h0);
    check("reset rsp_err",    rsp_err,    1'b0);
    check("reset alu_opcode", alu_opcode, 4'd0);
    check("reset alu_start",  alu_start,  1'b0);
    check("reset alu_a",      alu_a,      16'h0);
    @(negedge CLK) RESET_N = 1'b1;
    @(posedge CLK); #1;
    check("req_ready after reset", req_ready, 1'b1);

    for (int i = 0; i < 15; i++) run_vec(vecs[i]);

    // --- DIV timeout with response back-pressure ------------------------------
    div_hang  = 1'b1;
    rsp_ready = 1'b0;
    s0 = start_cnt;
    issue(4'd4, 16'd100, 16'd7);
    wait_rsp(4'd4, k, held);
    // One edge into DIV_START, then DIV_TIMEOUT cycles in DIV_WAIT.
    check("timeout latency", k, DIV_TIMEOUT + 1);
    check("timeout opcode held", held, 1'b1);
    check("timeout err", rsp_err, 1'b1);
    check("timeout result", rsp_result, 16'h0);
    check("timeout high", rsp_high, 16'h0);
    check("timeout flags", rsp_flags, 4'h0);
    check("timeout start cycles", start_cnt - s0, 1);
    check("timeout opcode released", alu_opcode, 4'd0);
    // A second request presented while the response is stalled is ignored.
    req_op    = 4'd1;
    req_a     = 16'd2;
    req_b     = 16'd3;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      check("stall rsp_valid", rsp_valid, 1'b1);
      check("stall rsp_err", rsp_err, 1'b1);
      check("stall rsp_result", rsp_result, 16'h0);
      check("stall req_ready", req_ready, 1'b0);
      check("stall opcode", alu_opcode, 4'd0);
    end
    rsp_ready = 1'b1;
    @(posedge CLK); #1;
    // Response consumed; the pending request must not be taken on this edge.
    check("release rsp_valid", rsp_valid, 1'b0);
    check("release req_ready", req_ready, 1'b1);
    check("release no accept", alu_opcode, 4'd0);
    @(posedge CLK); #1;
    check("next edge accept", alu_opcode, 4'd1);
    check("next edge busy", req_ready, 1'b0);
    req_valid = 1'b0;
    wait_rsp(4'd1, k, held);
    check("post-stall add latency", k, 2);
    check("post-stall add result", rsp_result, 16'd5);
    check("post-stall add flags", rsp_flags, 4'b1000);
    check("post-stall add high", rsp_high, 16'h0);
    @(posedge CLK); #1;
    check("post-stall idle", req_ready, 1'b1);

    // --- Reset during DIV_WAIT -----------------------------------------------
    issue(4'd4, 16'd100, 16'd7);
    repeat (5) @(posedge CLK);
    #1;
    check("div_wait opcode", alu_opcode, 4'd4);
    check("div_wait no rsp", rsp_valid, 1'b0);
    RESET_N = 1'b0;
    #1;
    check("mid reset alu_start", alu_start, 1'b0);
    check("mid reset alu_opcode", alu_opcode, 4'd0);
    check("mid reset rsp_valid", rsp_valid, 1'b0);
    repeat (2) @(posedge CLK);
    @(negedge CLK) begin
      RESET_N  = 1'b1;
      div_hang = 1'b0;
    end
    @(posedge CLK); #1;
    check("after reset no rsp", rsp_valid, 1'b0);
    run_vec('{"add_2_3", 4'd1, 16'd2, 16'd3, 16'd5, 16'h0, 4'b1000, 1'b0, 2, 0, 4'd1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
